// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: mem_op encodings (also used by the main
// decoder), FSM state encodings and an access-size helper.
package mem_pkg;

   localparam logic [2:0] MEM_W   = 3'b000;
   localparam logic [2:0] MEM_SH  = 3'b001;
   localparam logic [2:0] MEM_SB  = 3'b010;
   localparam logic [2:0] MEM_LH  = 3'b100;
   localparam logic [2:0] MEM_LHU = 3'b101;
   localparam logic [2:0] MEM_LB  = 3'b110;
   localparam logic [2:0] MEM_LBU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   // 011 and any other unlisted code fall through to word
   function automatic size_t op_size(input logic [2:0] op);
      case (op)
         MEM_SB, MEM_LB, MEM_LBU: op_size = SZ_BYTE;
         MEM_SH, MEM_LH, MEM_LHU: op_size = SZ_HALF;
         default:                 op_size = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory stage and the SRAM/bus bridge.
// Handshake: the master raises d_req with d_wr/d_be/d_addr/d_wdata stable and
// holds them until the slave pulses d_ack for one cycle; d_rdata is valid with d_ack.
interface mem_access_unit_if #(
   parameter int AW = 32
);
   logic          d_req;
   logic          d_wr;
   logic [3:0]    d_be;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata;
   logic          d_ack;

   modport master (
      output d_req, d_wr, d_be, d_addr, d_wdata,
      input  d_rdata, d_ack
   );

   modport slave (
      input  d_req, d_wr, d_be, d_addr, d_wdata,
      output d_rdata, d_ack
   );
endinterface

// File: rtl/mem_lane_ext.sv
// Combinational lane logic: byte enables, store-data replication, load
// extraction and misalignment detection from op and the low address bits.
module mem_lane_ext
   import mem_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic        is_store,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   size_t       size;
   logic        sign;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      size       = op_size(op);
      sign       = (op == MEM_LB) || (op == MEM_LH);
      sel_half   = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
      be         = 4'b1111;
      wdata_rep  = wdata;
      rdata_ext  = rdata_raw;
      misaligned = 1'b0;
      case (addr_lo)
         2'd0:    sel_byte = rdata_raw[7:0];
         2'd1:    sel_byte = rdata_raw[15:8];
         2'd2:    sel_byte = rdata_raw[23:16];
         default: sel_byte = rdata_raw[31:24];
      endcase
      // loads always fetch the full word; only stores narrow the enables
      case (size)
         SZ_BYTE: begin
            if (is_store) be = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{sign & sel_byte[7]}}, sel_byte};
         end
         SZ_HALF: begin
            if (is_store) be = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep  = {2{wdata[15:0]}};
            rdata_ext  = {{16{sign & sel_half[15]}}, sel_half};
            misaligned = addr_lo[0];
         end
         default: misaligned = |addr_lo;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one bus transaction per load/store, with stall, ack timeout,
// misalignment exceptions and extended load data.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255,
   parameter int AW          = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic          memwrite,
   input  logic          memtoreg,
   input  logic [2:0]    mem_op,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic          stall,
   output logic          done,
   output logic [31:0]   rdata,
   output logic          adel,
   output logic          ades,
   output logic          bus_err,
   output logic [AW-1:0] bad_addr,
   output state_t        dbg_state,
   mem_access_unit_if.master bus
);

   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [2:0]    op_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic          wr_q;
   logic [7:0]    cnt;

   logic          idle, in_req, access, timeout;
   logic [2:0]    lane_op;
   logic [1:0]    lane_lo;
   logic          lane_store;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata, lane_rdata;
   logic          lane_mis;

   // In IDLE the lane logic looks at the live request to decide alignment;
   // afterwards it works from the latched transaction.
   always_comb begin
      idle       = (state == S_IDLE);
      in_req     = (state == S_REQ);
      access     = req_valid && (memwrite || memtoreg);
      lane_op    = idle ? mem_op : op_q;
      lane_lo    = idle ? addr[1:0] : addr_q[1:0];
      lane_store = idle ? memwrite : wr_q;
   end

   mem_lane_ext u_lane (
      .op         (lane_op),
      .addr_lo    (lane_lo),
      .is_store   (lane_store),
      .wdata      (wdata_q),
      .rdata_raw  (bus.d_rdata),
      .be         (lane_be),
      .wdata_rep  (lane_wdata),
      .rdata_ext  (lane_rdata),
      .misaligned (lane_mis)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      timeout   = (cnt == CNT_LAST);
      case (state)
         S_IDLE: if (access) state_nxt = lane_mis ? S_DONE : S_REQ;
         S_REQ:  if (bus.d_ack || timeout) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // reset must release the pipeline even while req_valid is still up
      stall     = rst && ((idle && access) || in_req);
      done      = (state == S_DONE);
      dbg_state = state;
   end

   assign bus.d_req   = in_req;
   assign bus.d_wr    = in_req && wr_q;
   assign bus.d_be    = in_req ? lane_be : 4'b0000;
   assign bus.d_addr  = in_req ? {addr_q[AW-1:2], 2'b00} : '0;
   assign bus.d_wdata = in_req ? lane_wdata : 32'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q     <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         wr_q     <= 1'b0;
         cnt      <= 8'h00;
         rdata    <= 32'h0;
         adel     <= 1'b0;
         ades     <= 1'b0;
         bus_err  <= 1'b0;
         bad_addr <= '0;
      end else begin
         case (state)
            S_IDLE: if (access) begin
               op_q    <= mem_op;
               addr_q  <= addr;
               wdata_q <= wdata;
               wr_q    <= memwrite;
               cnt     <= 8'h00;
               if (lane_mis) begin
                  adel     <= !memwrite;
                  ades     <= memwrite;
                  bus_err  <= 1'b0;
                  rdata    <= 32'h0;
                  bad_addr <= addr;
               end
            end
            S_REQ: begin
               cnt <= cnt + 8'h01;
               if (bus.d_ack) begin
                  cnt     <= 8'h00;
                  rdata   <= wr_q ? 32'h0 : lane_rdata;
                  adel    <= 1'b0;
                  ades    <= 1'b0;
                  bus_err <= 1'b0;
               end else if (timeout) begin
                  cnt      <= 8'h00;
                  rdata    <= 32'h0;
                  adel     <= 1'b0;
                  ades     <= 1'b0;
                  bus_err  <= 1'b1;
                  bad_addr <= addr_q;
               end
            end
            default: cnt <= 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a size/shift based
// reference model of lane selection, extension, alignment and latency.
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        memwrite = 1'b0;
   logic        memtoreg = 1'b0;
   logic [2:0]  mem_op = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall, done, adel, ades, bus_err;
   logic [31:0] rdata, bad_addr;
   state_t      dbg_state;

   int total = 0;
   int bad = 0;

   mem_access_unit_if #(.AW(32)) dbus ();

   mem_access_unit #(.ACK_TIMEOUT(4), .AW(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .memwrite(memwrite),
      .memtoreg(memtoreg), .mem_op(mem_op), .addr(addr), .wdata(wdata),
      .stall(stall), .done(done), .rdata(rdata), .adel(adel), .ades(ades),
      .bus_err(bus_err), .bad_addr(bad_addr), .dbg_state(dbg_state), .bus(dbus)
   );

   always #5 clk = ~clk;

   // bus activity monitor, sampled mid-cycle
   int   rises = 0;
   int   dones = 0;
   logic req_prev = 1'b0;
   always @(negedge clk) begin
      if (dbus.d_req && !req_prev) rises++;
      req_prev = dbus.d_req;
      if (done) dones++;
   end

   // observations from the last run
   int          stall_cyc, req_cyc, lat;
   bit          done_seen, unstable;
   logic [3:0]  o_be;
   logic [31:0] o_wdata, o_addr, o_rdata, o_bad;
   logic        o_wr, o_adel, o_ades, o_berr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference model
   function automatic int sz(input logic [2:0] op);
      if (op == 3'b010 || op == 3'b110 || op == 3'b111) return 1;
      if (op == 3'b001 || op == 3'b100 || op == 3'b101) return 2;
      return 4;
   endfunction

   function automatic bit mis(input logic [2:0] op, input logic [31:0] a);
      return (a % sz(op)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input bit st, input logic [2:0] op, input logic [31:0] a);
      int n = sz(op);
      if (!st) return 4'hF;
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] op, input logic [31:0] wd);
      case (sz(op))
         1:       return (wd & 32'hFF) * 32'h01010101;
         2:       return (wd & 32'hFFFF) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] m_rd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
      int n = sz(op);
      longint v = (longint'(w) >> (8 * (a % 4))) & ((longint'(1) << (8 * n)) - 1);
      if ((op == 3'b110 || op == 3'b100) && v >= (longint'(1) << (8 * n - 1)))
         v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   task automatic drive(input bit w, input bit l, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1; memwrite = w; memtoreg = l; mem_op = op; addr = a; wdata = wd;
   endtask

   task automatic idle();
      req_valid = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
      @(negedge clk);
   endtask

   // Call right after a negedge with the request driven; returns inside the done cycle.
   task automatic run(input int ack_dly, input logic [31:0] bus_rd);
      stall_cyc = 0; req_cyc = 0; lat = 0; done_seen = 0; unstable = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         lat++;
         if (stall) stall_cyc++;
         if (dbus.d_req) begin
            if (req_cyc == 0) begin
               o_be = dbus.d_be; o_wdata = dbus.d_wdata; o_addr = dbus.d_addr; o_wr = dbus.d_wr;
            end else if (o_be !== dbus.d_be || o_wdata !== dbus.d_wdata ||
                         o_addr !== dbus.d_addr || o_wr !== dbus.d_wr) begin
               unstable = 1;
            end
            if (req_cyc == ack_dly) begin
               dbus.d_ack = 1'b1; dbus.d_rdata = bus_rd;
            end else begin
               dbus.d_ack = 1'b0; dbus.d_rdata = $urandom;
            end
            req_cyc++;
         end else begin
            dbus.d_ack = 1'b0;
         end
         if (done) begin
            done_seen = 1;
            o_rdata = rdata; o_adel = adel; o_ades = ades; o_berr = bus_err; o_bad = bad_addr;
            break;
         end
         @(negedge clk);
      end
      dbus.d_ack = 1'b0;
      chk("done_within_bound", 32'(done_seen), 32'd1);
   endtask

   int          r0, d0;
   bit          st;
   logic [2:0]  op;
   logic [31:0] a, wd, rd;
   int          dly;
   logic [2:0]  st_ops[4] = '{3'b000, 3'b001, 3'b010, 3'b011};
   logic [2:0]  ld_ops[6] = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

   initial begin
      dbus.d_ack = 1'b0;
      dbus.d_rdata = 32'h0;
      repeat (3) @(negedge clk);
      // reset state
      chk("rst_d_req", 32'(dbus.d_req), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_flags", {29'd0, adel, ades, bus_err}, 0);
      chk("rst_bad_addr", bad_addr, 0);
      chk("rst_bus", {dbus.d_addr ^ dbus.d_wdata, 28'd0, dbus.d_be} == 0 ? 32'd0 : 32'd1, 0);
      chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
      rst = 1'b1;
      @(negedge clk);

      // SB with zero-wait ack
      drive(1, 0, MEM_SB, 32'h1003, 32'h000000A5); run(0, 32'h0);
      chk("sb_be", 32'(o_be), 32'h8);
      chk("sb_wdata", o_wdata, 32'hA5A5A5A5);
      chk("sb_wr", 32'(o_wr), 1);
      chk("sb_addr", o_addr, 32'h1000);
      chk("sb_stall", stall_cyc, 2);
      chk("sb_latency", lat, 3);
      idle();

      // loads from one bus word
      drive(0, 1, MEM_LB, 32'h2002, 0); run(0, 32'h12F45678);
      chk("lb_rdata", o_rdata, 32'hFFFFFFF4);
      chk("lb_be", 32'(o_be), 32'hF);
      chk("lb_wr", 32'(o_wr), 0);
      idle();
      drive(0, 1, MEM_LBU, 32'h2002, 0); run(0, 32'h12F45678);
      chk("lbu_rdata", o_rdata, 32'h000000F4);
      idle();
      drive(0, 1, MEM_LH, 32'h2002, 0); run(1, 32'h12F45678);
      chk("lh_rdata", o_rdata, 32'h000012F4);
      chk("lh_latency", lat, 4);
      idle();
      drive(0, 1, MEM_LHU, 32'h2000, 0); run(0, 32'h12F45678);
      chk("lhu_rdata", o_rdata, 32'h00005678);
      idle();

      // ack never comes: four request cycles then bus error
      drive(1, 0, MEM_W, 32'h3100, 32'h11223344); run(-1, 0);
      chk("to_req_cycles", req_cyc, 4);
      chk("to_bus_err", 32'(o_berr), 1);
      chk("to_rdata", o_rdata, 0);
      chk("to_bad_addr", o_bad, 32'h3100);
      idle();
      drive(0, 1, MEM_W, 32'h3104, 0); run(0, 32'hDEADBEEF);
      chk("after_to_rdata", o_rdata, 32'hDEADBEEF);
      chk("after_to_bus_err", 32'(o_berr), 0);
      idle();

      // misaligned accesses never reach the bus
      drive(0, 1, MEM_W, 32'h3001, 0); run(0, 0);
      chk("lw_mis_req", req_cyc, 0);
      chk("lw_mis_latency", lat, 2);
      chk("lw_mis_adel", 32'(o_adel), 1);
      chk("lw_mis_bad", o_bad, 32'h3001);
      idle();
      drive(1, 0, MEM_SH, 32'h3003, 32'h5555); run(0, 0);
      chk("sh_mis_ades", 32'(o_ades), 1);
      chk("sh_mis_adel", 32'(o_adel), 0);
      chk("sh_mis_req", req_cyc, 0);
      idle();

      // reset in the middle of a slow load
      drive(0, 1, MEM_W, 32'h4000, 0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_d_req", 32'(dbus.d_req), 0);
      chk("midrst_stall", 32'(stall), 0);
      chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      r0 = rises;
      drive(1, 0, MEM_W, 32'h4004, 32'hA1B2C3D4);
      dbus.d_ack = 1'b1;  // stale ack from the aborted load, arriving while idle
      run(1, 0);
      chk("postrst_req_cycles", req_cyc, 2);
      chk("postrst_latency", lat, 4);
      chk("postrst_wdata", o_wdata, 32'hA1B2C3D4);
      chk("postrst_txns", rises - r0, 1);
      idle();

      // back-to-back LW then SW with req_valid held through DONE
      r0 = rises; d0 = dones;
      drive(0, 1, MEM_W, 32'h5000, 0); run(0, 32'hCAFEF00D);
      chk("b2b_lw_rdata", o_rdata, 32'hCAFEF00D);
      @(negedge clk);
      drive(1, 1, MEM_SB, 32'h5005, 32'h0000003C); run(0, 0);
      chk("b2b_sw_be", 32'(o_be), 32'h2);
      chk("b2b_sw_wr", 32'(o_wr), 1);
      chk("b2b_sw_latency", lat, 3);
      chk("b2b_txns", rises - r0, 2);
      chk("b2b_dones", dones - d0, 2);
      idle();

      // randomized accesses
      for (int i = 0; i < 60; i++) begin
         st  = bit'($urandom_range(0, 1));
         op  = st ? st_ops[$urandom_range(0, 3)] : ld_ops[$urandom_range(0, 5)];
         a   = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & ~(32'(sz(op)) - 32'd1);
         wd  = $urandom;
         rd  = $urandom;
         dly = $urandom_range(0, 2);
         drive(st, st ? bit'($urandom_range(0, 1)) : 1'b1, op, a, wd);
         run(dly, rd);
         if (mis(op, a)) begin
            chk("rnd_mis_req", req_cyc, 0);
            chk("rnd_mis_latency", lat, 2);
            chk("rnd_mis_flags", {30'd0, o_adel, o_ades}, st ? 32'd1 : 32'd2);
            chk("rnd_mis_bad", o_bad, a);
         end else begin
            chk("rnd_req_cycles", req_cyc, dly + 1);
            chk("rnd_latency", lat, dly + 3);
            chk("rnd_stable", 32'(unstable), 0);
            chk("rnd_addr", o_addr, a & 32'hFFFFFFFC);
            chk("rnd_wr", 32'(o_wr), 32'(st));
            chk("rnd_be", 32'(o_be), 32'(m_be(st, op, a)));
            chk("rnd_flags", {29'd0, o_adel, o_ades, o_berr}, 0);
            if (st) chk("rnd_wdata", o_wdata, m_wd(op, wd));
            else    chk("rnd_rdata", o_rdata, m_rd(op, a, rd));
         end
         idle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage that consumes the main decoder's memwrite, memtoreg and mem_op. It issues one data-bus transaction per load/store and generates byte enables and lane-replicated store data.
- Extracts and sign/zero-extends load data, and flags misaligned addresses.
- Holds the pipeline through stall while a transaction is outstanding. It sits between the EX/MEM register and the data SRAM/bus bridge.

Parameters:
- ACK_TIMEOUT, 255, max cycles spent in REQ waiting for d_ack before aborting with bus_err (8-bit counter; must be 1..255)
- AW, 32, address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  EX/MEM holds a valid load/store this cycle
- memwrite  in  1  store (decoder)
- memtoreg  in  1  load (decoder)
- mem_op  in  3  access kind; shared encoding, see Decomposition
- addr  in  AW  effective address
- wdata  in  32  store source (rt)
- stall  out  1  freeze upstream stages
- done  out  1  one-cycle completion pulse; rdata/exception outputs valid with it
- rdata  out  32  extended load result
- adel  out  1  load address misaligned (valid with done)
- ades  out  1  store address misaligned (valid with done)
- bus_err  out  1  ack timeout (valid with done)
- bad_addr  out  AW  offending address (valid with done)
- d_req  out  1  bus request, held until ack
- d_wr  out  1  1 = write
- d_be  out  4  byte enables, bit0 = addr byte 0 (little-endian)
- d_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- d_wdata  out  32  lane-replicated store data
- d_rdata  in  32  read data, valid with d_ack
- d_ack  in  1  transaction complete

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset asserted mid-transaction drops d_req immediately and returns to IDLE; the transaction is not retried.
- FSM states:
  - IDLE: if req_valid && (memwrite|memtoreg), latch op, addr, wdata and direction.
    - Aligned: go to REQ.
    - Misaligned: go to DONE with adel (load) or ades (store); no bus cycle is issued.
  - REQ: d_req=1, d_wr, d_be, d_addr and d_wdata are driven from registers and stay stable. Counter increments each cycle.
    - d_ack: capture d_rdata, go to DONE.
    - Counter == ACK_TIMEOUT-1 without ack: drop d_req, go to DONE with bus_err=1 and rdata=0.
  - DONE: done=1 for one cycle, then return to IDLE unconditionally. A req_valid seen in DONE is ignored; the next instruction is taken from IDLE.
- Stall: stall = (IDLE && req_valid && (memwrite|memtoreg)) || REQ. stall is 0 in DONE, so the pipeline advances on the DONE edge.
- Minimum latency with zero-wait ack: accept cycle, REQ cycle, DONE cycle. That gives 2 stall cycles.
- Alignment rules:
  - Word (000/011) requires addr[1:0]==0.
  - Half (001/100/101) requires addr[0]==0.
  - Byte is always aligned.
- Store lanes:
  - Word: be=1111, data=wdata.
  - Half: be=addr[1]?1100:0011, data={2{wdata[15:0]}}.
  - Byte: be=0001<<addr[1:0], data={4{wdata[7:0]}}.
- Loads use be=1111 and d_wr=0. Extraction uses the latched addr[1:0]:
  - LB sign-extends the selected byte; LBU zero-extends it.
  - LH sign-extends the selected half; LHU zero-extends it.
  - LW passes the word through.
- mem_op 011 is treated as word.
- memwrite and memtoreg both high: the store wins.
- d_ack outside REQ is ignored. An ack in the same cycle d_req first rises is accepted.
- adel, ades, bus_err, rdata and bad_addr are registered. They hold their last value and are qualified only by done.

Decomposition:
- Shared package mem_pkg holds the mem_op localparams, also used by the main decoder: MEM_W=000, MEM_SH=001, MEM_SB=010, MEM_LH=100, MEM_LHU=101, MEM_LB=110, MEM_LBU=111.
- The package also holds the FSM state encodings S_IDLE, S_REQ and S_DONE.
- One combinational sub-module, mem_lane_ext, takes op and addr[1:0]. It produces be, replicated wdata, extracted rdata and the misaligned flag, and can be reused by the cache path.

Test Plan:
- SB, addr=0x1003, wdata=0x000000A5, ack on first REQ cycle → d_be=1000, d_wdata=0xA5A5A5A5, d_wr=1, d_addr=0x1000, stall high 2 cycles, done on cycle 3.
- LB, addr=0x2002, d_rdata=0x12F4_5678 → rdata=0xFFFFFFF4. LBU at the same address → 0x000000F4. LH at 0x2002 → 0x000012F4. LHU at 0x2000 → 0x00005678.
- LW, addr=0x3001 → no d_req, done next cycle with adel=1, bad_addr=0x3001. SH, addr=0x3003 → ades=1.
- SW, ACK_TIMEOUT=4, d_ack never asserted → d_req high exactly 4 cycles, then done with bus_err=1 and rdata=0. The next LW completes normally.
- LW with ack delayed 5 cycles; rst pulled low on cycle 3 → d_req=0 and stall=0 immediately. After release, a fresh SW issues a single transaction and the late ack is ignored.
- Back-to-back LW, SW with req_valid held through DONE → exactly two bus transactions and two done pulses, with no duplicate issue.
